// File: rtl/enable_register_pkg.sv
// Shared defaults for the enable_register storage primitive.
package enable_register_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

endpackage

// File: rtl/enable_register.sv
// Edge-triggered WIDTH-bit register with load enable; synchronous active-high reset has priority.
// One-edge latency from in to out, no bypass; out comes straight from the flops.
module enable_register
  import enable_register_pkg::*;
#(
  parameter int unsigned           WIDTH       = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out
);

  always_ff @(posedge clk) begin
    if (reset) begin
      out <= RESET_VALUE;
    end else if (en) begin
      out <= in;
    end
  end

endmodule

// File: tb/tb_enable_register.sv
// Bench for enable_register: three instances checked against a per-instance stored-value model.
module tb_enable_register;

  logic        clk = 1'b0;
  logic        rst8, en8, rst16, en16, rstb, enb;
  logic [7:0]  in8,  out8;
  logic [15:0] in16, out16, inb, outb;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Model: value each instance must hold, and whether it is defined yet.
  logic [15:0] exp_val [3];
  bit          known   [3];

  always #5 clk = ~clk;

  enable_register #(.WIDTH(8)) u8 (
    .clk(clk), .reset(rst8), .en(en8), .in(in8), .out(out8));
  enable_register #(.WIDTH(16)) u16 (
    .clk(clk), .reset(rst16), .en(en16), .in(in16), .out(out16));
  enable_register #(.WIDTH(16), .RESET_VALUE(16'hBEEF)) ub (
    .clk(clk), .reset(rstb), .en(enb), .in(inb), .out(outb));

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference behaviour: what each register must hold after this edge.
  always @(posedge clk) begin
    if (rst8) begin exp_val[0] <= 16'h0000; known[0] <= 1'b1; end
    else if (en8) begin exp_val[0] <= {8'h00, in8}; known[0] <= 1'b1; end
    if (rst16) begin exp_val[1] <= 16'h0000; known[1] <= 1'b1; end
    else if (en16) begin exp_val[1] <= in16; known[1] <= 1'b1; end
    if (rstb) begin exp_val[2] <= 16'hBEEF; known[2] <= 1'b1; end
    else if (enb) begin exp_val[2] <= inb; known[2] <= 1'b1; end
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      known[i]   = 1'b0;
      exp_val[i] = '0;
    end
  end

  always @(negedge clk) begin
    if (known[0]) chk("model_out8",  {8'h00, out8}, exp_val[0]);
    if (known[1]) chk("model_out16", out16, exp_val[1]);
    if (known[2]) chk("model_outb",  outb,  exp_val[2]);
  end

  initial begin
    rst8 = 1'b1; en8 = 1'b0; in8 = '0;
    rst16 = 1'b1; en16 = 1'b0; in16 = '0;
    rstb = 1'b1; enb = 1'b0; inb = '0;
    cyc();
    cyc();
    chk("reset_out8",  {8'h00, out8}, 16'h0000);
    chk("reset_out16", out16, 16'h0000);
    chk("reset_outb",  outb,  16'hBEEF);

    // Load zero
    rst8 = 1'b0; rst16 = 1'b0; rstb = 1'b0;
    en8 = 1'b1; en16 = 1'b1; in8 = 8'h00; in16 = 16'h0000;
    cyc();
    chk("load_zero8",  {8'h00, out8}, 16'h0000);
    chk("load_zero16", out16, 16'h0000);

    // Hold
    en8 = 1'b0; en16 = 1'b0; in8 = 8'hEF; in16 = 16'hABCD;
    cyc();
    chk("hold8",  {8'h00, out8}, 16'h0000);
    chk("hold16", out16, 16'h0000);

    // Enabled load, nothing visible before the edge
    en8 = 1'b1; en16 = 1'b1; in8 = 8'h56; in16 = 16'h1234;
    #3;
    chk("pre_edge8",  {8'h00, out8}, 16'h0000);
    chk("pre_edge16", out16, 16'h0000);
    cyc();
    chk("load8",  {8'h00, out8}, 16'h0056);
    chk("load16", out16, 16'h1234);

    // Reset beats enable, then reload on release
    rst8 = 1'b1; en8 = 1'b1; in8 = 8'hFF;
    cyc();
    chk("rst_prio8", {8'h00, out8}, 16'h0000);
    rst8 = 1'b0;
    cyc();
    chk("rst_release8", {8'h00, out8}, 16'h00FF);

    // Reset pulse between edges is ignored
    in8 = 8'h56;
    cyc();
    chk("reload8", {8'h00, out8}, 16'h0056);
    en8 = 1'b0;
    #2 rst8 = 1'b1;
    #3 rst8 = 1'b0;
    cyc();
    chk("async_pulse8", {8'h00, out8}, 16'h0056);

    // Non-default reset value
    rstb = 1'b1; enb = 1'b0;
    cyc();
    chk("beef_reset", outb, 16'hBEEF);
    rstb = 1'b0; enb = 1'b1; inb = 16'h0001;
    cyc();
    chk("beef_load", outb, 16'h0001);

    // Random traffic, checked by the model every cycle
    for (int n = 0; n < 400; n++) begin
      rst8  = ($urandom_range(0, 7) == 0);
      rst16 = ($urandom_range(0, 7) == 0);
      rstb  = ($urandom_range(0, 7) == 0);
      en8   = 1'($urandom);
      en16  = 1'($urandom);
      enb   = 1'($urandom);
      in8   = 8'($urandom);
      in16  = 16'($urandom);
      inb   = 16'($urandom);
      cyc();
    end

    rst8 = 1'b0; rst16 = 1'b0; rstb = 1'b0;
    en8 = 1'b0; en16 = 1'b0; enb = 1'b0;
    cyc();
    cyc();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
